// File: rtl/pdcch_dmrs_controller_if.sv
// Purpose : stream bundle for the PDCCH DMRS controller: the config word in, per-symbol PN config out.
// Latency : none, this is wiring only.
// Backpressure: s_axis_* and m_axis_* are plain valid/ready pairs; sym_idx travels alongside m_axis_data.
// Ports   : slave  = controller side (takes config, drives per-symbol output)
//           master = environment side (drives config, takes per-symbol output)
interface pdcch_dmrs_controller_if #(
  parameter int IP_DW = 110,
  parameter int OP_DW = 105
);
  logic [IP_DW-1:0] s_axis_data;
  logic             s_axis_valid;
  logic             s_axis_ready;
  logic [OP_DW-1:0] m_axis_data;
  logic             m_axis_valid;
  logic             m_axis_ready;
  logic [3:0]       sym_idx;

  modport slave (
    input  s_axis_data, s_axis_valid, m_axis_ready,
    output s_axis_ready, m_axis_data, m_axis_valid, sym_idx
  );

  modport master (
    output s_axis_data, s_axis_valid, m_axis_ready,
    input  s_axis_ready, m_axis_data, m_axis_valid, sym_idx
  );
endinterface

// File: rtl/pdcch_dmrs_controller.sv
// Purpose : turns one PDCCH top-config word into one PN-generator config per CORESET OFDM symbol.
// Latency : m_axis_valid rises 3 cycles after the input handshake, and 3 cycles after each output handshake.
// Backpressure: one config at a time (s_axis_ready only in IDLE); output is held stable until m_axis_ready.
// Ports   : clk, reset (sync, active high); bus (slave modport: s_axis_*, m_axis_*, sym_idx);
//           busy (not IDLE), done (1-cycle pulse at end of config), err (1-cycle pulse on a bad config).
module pdcch_dmrs_controller #(
  parameter int IP_DW = 110,
  parameter int OP_DW = 105
) (
  input  logic                    clk,
  input  logic                    reset,
  pdcch_dmrs_controller_if.slave  bus,
  output logic                    busy,
  output logic                    done,
  output logic                    err
);

  typedef enum logic [1:0] {IDLE, CALC1, CALC2, EMIT} state_t;

  // Input field views
  logic [1:0]  in_coreset;
  logic [6:0]  in_slot;
  logic [15:0] in_nid;
  logic [3:0]  in_start;
  logic [12:0] in_offset;
  logic [44:0] in_bitmap;
  logic [1:0]  in_dur;
  logic [4:0]  in_last_sym;
  logic        in_ovf;

  assign in_coreset = bus.s_axis_data[88:87];
  assign in_slot    = bus.s_axis_data[86:80];
  assign in_nid     = bus.s_axis_data[79:64];
  assign in_start   = bus.s_axis_data[63:60];
  assign in_offset  = bus.s_axis_data[57:45];
  assign in_bitmap  = bus.s_axis_data[44:0];

  // A zero-length CORESET is run as a single symbol.
  assign in_dur      = (in_coreset == 2'd0) ? 2'd1 : in_coreset;
  assign in_last_sym = {1'b0, in_start} + {3'b0, in_dur} - 5'd1;
  assign in_ovf      = (in_last_sym > 5'd13);

  // Highest set bit of the frequency bitmap sets the PN length (36 bits per RB group).
  logic [5:0]  hi_bit;
  logic [15:0] pn_calc;

  always_comb begin
    hi_bit = 6'd0;
    for (int i = 0; i < 45; i++) begin
      if (in_bitmap[i]) hi_bit = i[5:0];
    end
  end

  assign pn_calc = ({10'd0, hi_bit} + 16'd1) * 16'd36;

  // State
  state_t           state_q, state_d;
  logic             s_ready_q, s_ready_d;
  logic             m_valid_q, m_valid_d;
  logic [OP_DW-1:0] m_data_q, m_data_d;
  logic [3:0]       l_q, l_d;
  logic [1:0]       k_q, k_d;
  logic [1:0]       dur_q, dur_d;
  logic [6:0]       slot_q, slot_d;
  logic [15:0]      nid_q, nid_d;
  logic [12:0]      offset_q, offset_d;
  logic [44:0]      bitmap_q, bitmap_d;
  logic [15:0]      pn_len_q, pn_len_d;
  logic             ovf_q, ovf_d;
  logic [10:0]      a_q, a_d;
  logic [16:0]      b_q, b_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  // Only the low 14 bits of a*b survive the shift into the 31-bit C_init.
  logic [27:0] prod;
  logic [13:0] p;
  logic [30:0] cinit;

  assign prod  = {17'd0, a_q} * {11'd0, b_q};
  assign p     = prod[13:0];
  assign cinit = {p, 17'd0} + {14'd0, nid_q, 1'b0};

  // Bandwidth-part fields and start_symbol_index play no part in the DMRS config.
  logic unused_bits;
  assign unused_bits = ^{bus.s_axis_data[IP_DW-1:89], bus.s_axis_data[59:58], prod[27:14]};

  always_comb begin
    state_d   = state_q;
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    l_d       = l_q;
    k_d       = k_q;
    dur_d     = dur_q;
    slot_d    = slot_q;
    nid_d     = nid_q;
    offset_d  = offset_q;
    bitmap_d  = bitmap_q;
    pn_len_d  = pn_len_q;
    ovf_d     = ovf_q;
    a_d       = a_q;
    b_d       = b_q;
    done_d    = 1'b0;
    err_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.s_axis_valid && s_ready_q) begin
          slot_d   = in_slot;
          nid_d    = in_nid;
          offset_d = in_offset;
          bitmap_d = in_bitmap;
          dur_d    = in_dur;
          pn_len_d = pn_calc;
          ovf_d    = in_ovf;
          l_d      = in_start;
          k_d      = 2'd0;
          if (in_bitmap == 45'd0) begin
            // Nothing to emit: report and finish immediately.
            done_d = 1'b1;
            err_d  = 1'b1;
          end else begin
            err_d   = (in_coreset == 2'd0);
            state_d = CALC1;
          end
        end
      end

      CALC1: begin
        a_d     = {4'd0, slot_q} * 11'd14 + {7'd0, l_q} + 11'd1;
        b_d     = {nid_q, 1'b1};
        state_d = CALC2;
      end

      CALC2: begin
        m_data_d  = {cinit, pn_len_q, offset_q, bitmap_q};
        m_valid_d = 1'b1;
        state_d   = EMIT;
      end

      EMIT: begin
        if (bus.m_axis_ready) begin
          m_valid_d = 1'b0;
          // Stop at the CORESET length or at the last symbol of the slot, whichever is first.
          if ((k_q < dur_q - 2'd1) && (l_q < 4'd13)) begin
            k_d     = k_q + 2'd1;
            l_d     = l_q + 4'd1;
            state_d = CALC1;
          end else begin
            done_d  = 1'b1;
            err_d   = ovf_q;
            state_d = IDLE;
          end
        end
      end

      default: state_d = IDLE;
    endcase

    s_ready_d = (state_d == IDLE);
    busy_d    = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      s_ready_q <= 1'b1;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      l_q       <= 4'd0;
      k_q       <= 2'd0;
      dur_q     <= 2'd1;
      slot_q    <= 7'd0;
      nid_q     <= 16'd0;
      offset_q  <= 13'd0;
      bitmap_q  <= 45'd0;
      pn_len_q  <= 16'd0;
      ovf_q     <= 1'b0;
      a_q       <= 11'd0;
      b_q       <= 17'd0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      s_ready_q <= s_ready_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      l_q       <= l_d;
      k_q       <= k_d;
      dur_q     <= dur_d;
      slot_q    <= slot_d;
      nid_q     <= nid_d;
      offset_q  <= offset_d;
      bitmap_q  <= bitmap_d;
      pn_len_q  <= pn_len_d;
      ovf_q     <= ovf_d;
      a_q       <= a_d;
      b_q       <= b_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign bus.s_axis_ready = s_ready_q;
  assign bus.m_axis_valid = m_valid_q;
  assign bus.m_axis_data  = m_data_q;
  assign bus.sym_idx      = l_q;
  assign busy             = busy_q;
  assign done             = done_q;
  assign err              = err_q;

endmodule

// File: doc/pdcch_dmrs_controller.md
PDCCH_DMRS_CONTROLLER -- requirements
Module: pdcch_dmrs_controller

Interface
REQ-001 SHALL have parameter IP_DW, default 110, meaning width of the top-config word (pucch_top_configs_1).
REQ-002 SHALL have parameter OP_DW, default 105, meaning width of the controller-config word (pdcch_controller_configs_1).
REQ-003 SHALL have port clk, input, 1, the single clock; all logic on rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port s_axis_data, input, IP_DW, top-config word. Fields MSB-first: Bwpsize[109:101], Bwpstart[100:89], coreset[88:87] (duration in symbols), slotnumber[86:80], N_id[79:64], start_symbol[63:60], start_symbol_index[59:58], dmrs_offset[57:45], freq_bitmap[44:0].
REQ-006 SHALL have ports s_axis_valid (input, 1) and s_axis_ready (output, 1): AXI-stream handshake for the config word.
REQ-007 SHALL have port m_axis_data, output, OP_DW, per-symbol PN config. Fields: C_init[104:74], Pn_Sequence_length[73:58], dmrs_offset[57:45], freq_bit_map[44:0].
REQ-008 SHALL have ports m_axis_valid (output, 1) and m_axis_ready (input, 1): AXI-stream handshake for the per-symbol config.
REQ-009 SHALL have port sym_idx, output, 4, OFDM symbol number carried by the current m_axis_data.
REQ-010 SHALL have ports busy (output, 1), done (output, 1, one-cycle pulse) and err (output, 1, one-cycle pulse).

Function
REQ-011 SHALL implement the FSM states IDLE, CALC1, CALC2, EMIT.
REQ-012 IDLE SHALL drive s_axis_ready=1. On s_axis_valid&s_axis_ready, the FSM SHALL register the config, set l=start_symbol and k=0, and go to CALC1. Input words SHALL be accepted in no other state.
REQ-013 The duration D SHALL equal coreset. D=0 SHALL be treated as D=1 and SHALL pulse err in the cycle after acceptance.
REQ-014 freq_bitmap==0 SHALL cause no emission. In that case err and done SHALL pulse together in the cycle after acceptance, and the FSM SHALL return to IDLE.
REQ-015 CALC1 SHALL register a=14*slotnumber+l+1 (11 bits) and b=2*N_id+1 (17 bits).
REQ-016 CALC2 SHALL register p=a*b, keeping only the low 14 bits.
REQ-017 C_init SHALL equal ({p[13:0],17'b0} + {N_id,1'b0}) mod 2^31. This equals (2^17*(14*ns+l+1)*(2*N_id+1)+2*N_id) mod 2^31.
REQ-018 Pn_Sequence_length SHALL equal 36*(h+1), where h is the index of the highest set bit of freq_bitmap, giving range 36..1620. It SHALL be computed once per accepted config.
REQ-019 dmrs_offset and freq_bit_map SHALL pass through unchanged from the registered config.
REQ-020 EMIT SHALL assert m_axis_valid. m_axis_data and sym_idx=l SHALL stay stable until m_axis_ready=1.
REQ-021 A handshake in EMIT with k<D-1 and l<13 SHALL increment k and l and go to CALC1.
REQ-022 A handshake in EMIT otherwise SHALL pulse done next cycle and go to IDLE.
REQ-023 Latency SHALL be: m_axis_valid first rises 3 cycles after the input handshake cycle. Each next symbol's m_axis_valid SHALL rise 3 cycles after the previous output handshake.
REQ-024 If start_symbol+D-1>13, emission SHALL stop after symbol 13, and err SHALL pulse together with done.
REQ-025 start_symbol_index, Bwpsize and Bwpstart SHALL be ignored.
REQ-026 busy SHALL be 1 in every state except IDLE.
REQ-027 m_axis_valid SHALL never deassert without a handshake.

Reset
REQ-028 With reset=1 at a clock edge, the next state SHALL be IDLE with s_axis_ready=1, m_axis_valid=0, m_axis_data=0, sym_idx=0, busy=0, done=0, err=0.
REQ-029 Reset mid-operation SHALL discard the pending config and SHALL NOT complete any in-flight output.

Verification
REQ-030 Basic case: slot=0, N_id=0, start_symbol=0, coreset=2, freq_bitmap=0x1, m_axis_ready=1 -> two outputs: C_init=0x20000 (sym 0), then 0x40000 (sym 1); both Pn_Sequence_length=36; then one done pulse.
REQ-031 Cross-check case: slot=1, N_id=1, start_symbol=2, coreset=1, freq_bitmap=0x100 -> C_init=0x660002, Pn_Sequence_length=324, sym_idx=2.
REQ-032 Backpressure: m_axis_ready random 50% for 200 cycles, coreset=3 -> exactly three outputs with data held stable while stalled, s_axis_ready=0 throughout, one done pulse.
REQ-033 Boundaries: start_symbol=13, coreset=3 -> one output with sym_idx=13, then err and done pulse together. freq_bitmap=0 -> no output, err and done pulse together. coreset=0 -> err pulse, then one output.
REQ-034 Reset mid-operation: assert reset while in EMIT with m_axis_ready=0 -> next cycle all outputs at reset values, no done pulse. A new config after reset is processed normally.
REQ-035 Back-to-back configs: s_axis_valid held high with two configs -> second accepted only after the first's done, and outputs are in order.
